// File: rtl/dram_read_master.sv
`default_nettype none
// ============================================================================
// Module      : dram_read_master
// Description : AXI4 read master turning one (addr, len) request pulse into
//               INCR read bursts and streaming the returned beats out.
//               Optional macro DRAM_READ_4K_SPLIT_EN splits bursts that
//               would cross a 4KB boundary into two back-to-back bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_read_master #(
    parameter int DRAM_ADDR_WIDTH = 39,
    parameter int DRAM_DATA_WIDTH = 128,
    parameter int AXI_ID          = 0
) (
    input  logic                       s_axi_aclk,
    input  logic                       dram_reader_reset,
    input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
    input  logic [7:0]                 dram_read_len,
    input  logic                       dram_read_en,
    input  logic                       dram_buffer_full,
    output logic                       dram_read_busy,
    output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
    output logic                       dram_read_data_valid,
    output logic                       dram_read_error,
    output logic                       dram_read_drop,
    output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic [5:0]                 m_axi_arid,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    localparam int c_BPB  = DRAM_DATA_WIDTH / 8;
    localparam int c_SIZE = $clog2(c_BPB);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_DATA  = 2'd2,
        S_ADDR2 = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_beat_idx;

    logic [DRAM_ADDR_WIDTH-1:0] w_addr_aligned;
    logic                       w_beat;
    logic                       w_unused_ok;

    assign m_axi_arsize   = 3'(c_SIZE);
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arid     = 6'(AXI_ID);
    assign w_addr_aligned = {dram_read_addr[DRAM_ADDR_WIDTH-1:c_SIZE], {c_SIZE{1'b0}}};
    assign w_beat         = m_axi_rvalid & m_axi_rready;
    assign w_unused_ok    = &{1'b0, m_axi_rresp[0], dram_read_addr[c_SIZE-1:0]};

`ifdef DRAM_READ_4K_SPLIT_EN
    logic [12:0]                 w_offset;
    logic [19:0]                 w_end;
    logic                        w_cross;
    logic [12:0]                 w_room;
    logic [7:0]                  w_len1;
    logic [7:0]                  w_len2;
    logic [DRAM_ADDR_WIDTH-13:0] w_page_next;
    logic [DRAM_ADDR_WIDTH-1:0]  w_addr2;
    logic                        r_split_pend;
    logic [DRAM_ADDR_WIDTH-1:0]  r_addr2;
    logic [7:0]                  r_len2;

    // First burst runs up to the 4KB edge, the second starts on the next page.
    assign w_offset    = {1'b0, w_addr_aligned[11:0]};
    assign w_end       = 20'(w_offset) + ((20'(dram_read_len) + 20'd1) << c_SIZE);
    assign w_cross     = w_end > 20'd4096;
    assign w_room      = 13'd4096 - w_offset;
    assign w_len1      = 8'((w_room >> c_SIZE) - 13'd1);
    assign w_len2      = dram_read_len - w_len1 - 8'd1;
    assign w_page_next = w_addr_aligned[DRAM_ADDR_WIDTH-1:12] + {{(DRAM_ADDR_WIDTH-13){1'b0}}, 1'b1};
    assign w_addr2     = {w_page_next, 12'h000};
`endif

    always_ff @(posedge s_axi_aclk) begin
        if (dram_reader_reset) begin
            r_state              <= S_IDLE;
            r_beat_idx           <= 8'd0;
            dram_read_busy       <= 1'b0;
            dram_read_data       <= '0;
            dram_read_data_valid <= 1'b0;
            dram_read_error      <= 1'b0;
            dram_read_drop       <= 1'b0;
            m_axi_araddr         <= '0;
            m_axi_arlen          <= 8'd0;
            m_axi_arvalid        <= 1'b0;
            m_axi_rready         <= 1'b0;
`ifdef DRAM_READ_4K_SPLIT_EN
            r_split_pend         <= 1'b0;
            r_addr2              <= '0;
            r_len2               <= 8'd0;
`endif
        end else begin
            dram_read_data_valid <= 1'b0;
            if (w_beat) begin
                dram_read_data       <= m_axi_rdata;
                dram_read_data_valid <= 1'b1;
            end
            if (dram_read_en && (r_state != S_IDLE)) begin
                dram_read_drop <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (dram_read_en) begin
                        dram_read_busy <= 1'b1;
                        m_axi_arvalid  <= 1'b1;
                        m_axi_araddr   <= w_addr_aligned;
                        m_axi_arlen    <= dram_read_len;
                        r_state        <= S_ADDR;
`ifdef DRAM_READ_4K_SPLIT_EN
                        r_split_pend   <= w_cross;
                        r_addr2        <= w_addr2;
                        r_len2         <= w_len2;
                        if (w_cross) begin
                            m_axi_arlen <= w_len1;
                        end
`endif
                    end
                end

                S_ADDR, S_ADDR2: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= ~dram_buffer_full;
                        r_beat_idx    <= 8'd0;
                        r_state       <= S_DATA;
                    end
                end

                S_DATA: begin
                    m_axi_rready <= ~dram_buffer_full;
                    if (w_beat) begin
                        r_beat_idx <= r_beat_idx + 8'd1;
                        // Protocol faults are flagged, but only rlast ends the burst.
                        if (m_axi_rresp[1] || (m_axi_rlast != (r_beat_idx == m_axi_arlen))) begin
                            dram_read_error <= 1'b1;
                        end
                        if (m_axi_rlast) begin
                            m_axi_rready <= 1'b0;
`ifdef DRAM_READ_4K_SPLIT_EN
                            if (r_split_pend) begin
                                r_split_pend  <= 1'b0;
                                m_axi_araddr  <= r_addr2;
                                m_axi_arlen   <= r_len2;
                                m_axi_arvalid <= 1'b1;
                                r_state       <= S_ADDR2;
                            end else begin
                                dram_read_busy <= 1'b0;
                                r_state        <= S_IDLE;
                            end
`else
                            dram_read_busy <= 1'b0;
                            r_state        <= S_IDLE;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
